se_channel_scaler: RTL
======================

// Module: se_channel_scaler
// PURPOSE
//  Squeeze-excite excitation stage, directly downstream of H_Sigmoid. Captures NUM_CH per-channel
//  hard-sigmoid gates (Q8.8) into a scale buffer, then streams the feature map, multiplying each
//  pixel by its channel gate. Output is Q8.8 with round-half-up and saturation.
//  Sits between the SE gate path and the pointwise-projection input buffer.
// PARAMETERS
//  DATA_WIDTH     16  sample width, signed fixed point
//  FRACTION_BITS  8   fraction bits (Q8.8)
//  NUM_CH         16  channels per frame (= gates per load), >=2
//  NUM_PIX        49  spatial positions per frame, >=1
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    asynchronous, active-high reset
//  scale_valid  in   1    gate word present on scale_in (H_Sigmoid valid), no back-pressure
//  scale_in     in   DW   signed Q8.8 gate, nominal range [0, 1.0 = 0x0100]
//  feat_valid   in   1    feature sample offered
//  feat_ready   out  1    scaler accepts feature sample this cycle
//  feat_in      in   DW   signed Q8.8 sample, channel-interleaved (ch0..chN-1 per pixel)
//  out_valid    out  1    out_data valid
//  out_ready    in   1    consumer accepts out_data
//  out_data     out  DW   signed Q8.8 scaled sample
//  out_last     out  1    marks final sample of frame (qualified by out_valid)
//  busy         out  1    high in any state except IDLE
//  done         out  1    one-cycle pulse when frame fully drained
//  scale_err    out  1    sticky: scale_valid seen in SCALE/DRAIN; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; all counters 0; pipeline valids 0. Scale RAM not cleared.
//  FSM: IDLE -scale_valid-> LOAD (that word written to entry 0, wr_ptr=1).
//   LOAD: each scale_valid writes entry wr_ptr, wr_ptr++; write of entry NUM_CH-1 -> SCALE.
//   SCALE: feat handshake (feat_valid & feat_ready); ch_cnt++ per beat, wraps NUM_CH-1->0 and
//    then pix_cnt++; beat with ch_cnt=NUM_CH-1 & pix_cnt=NUM_PIX-1 is last -> DRAIN.
//   DRAIN: feat_ready=0; when both pipeline stages empty and last output handshaken ->
//    done=1 for one cycle, state -> IDLE, counters cleared.
//  feat_ready = (state==SCALE) & adv, adv = ~s1_valid | ~s2_valid | out_ready (stalls only when
//   both stages are full and out_ready=0). feat_ready=0 in IDLE/LOAD/DRAIN.
//  Pipeline, latency 2 cycles accept->out_valid when unstalled, 1 sample/cycle throughput:
//   S1: prod = feat_in * scale_ram[ch_cnt] (2*DW signed), last flag registered alongside.
//   S2: r = (prod + 2^(FB-1)) >>> FB (arithmetic); saturate to [-2^(DW-1), 2^(DW-1)-1];
//       drives out_data/out_last/out_valid. Each stage holds when next stage full and stalled.
//  out_data/out_last stable while out_valid & ~out_ready (no drop, no duplicate).
//  scale_valid in IDLE/LOAD never dropped; in SCALE/DRAIN ignored (RAM unchanged), scale_err set.
//  Gates are not range-checked: any signed value is used as-is.
//  Simultaneous: done and a new scale_valid in same cycle -> scale_valid ignored, scale_err set.
//  rst mid-frame: pipeline flushed, partial frame discarded, next frame needs a full gate reload.
// STRUCTURE
//  Shared package: DATA_WIDTH/FRACTION_BITS defaults, Q8.8 ONE/HALF constants, sat/round function,
//   FSM state enum {IDLE, LOAD, SCALE, DRAIN} (2-bit).
//  One sub-module: qmul_round_sat (registered signed multiply + round + saturate, with stall
//   enable); FSM, counters, scale RAM (NUM_CH x DW regs) live in the top.
// TESTING
//  Identity: load 16 gates 0x0100, stream 49x16 ramp samples -> out_data == feat_in, order kept,
//   out_last only on sample 784, done pulse once, busy low afterwards.
//  Rounding: gate 0x0080 (0.5), feat 0x0101 -> 0x0081; feat 0xFEFF (-1.0039) -> 0xFF80.
//  Saturation: gate 0x7FFF, feat 0x7FFF -> 0x7FFF; gate 0x0200, feat 0x8000 -> 0x8000.
//  Back-pressure: hold out_ready=0 for 5 cycles mid-frame -> out_data held, feat_ready low once
//   both stages full, zero loss/duplication versus golden model; random out_ready 50% same check.
//  Per-channel: gates ch k = k*16 -> sample on channel k scaled by k/16; ch_cnt wraps correctly.
//  Reset/error: scale_valid during SCALE -> scale_err=1, outputs unaffected; assert rst at pixel 20
//   -> all outputs 0 next cycle, fresh load+frame then matches golden model.

Source files
------------

// File: rtl/se_channel_scaler_pkg.sv
// ---------------------------------------------------------------------------
// se_channel_scaler_pkg
//   Shared definitions for the squeeze-excite channel scaler slice.
//   - Default sample geometry (Q8.8, 16 channels, 49 pixels per frame)
//   - Q8.8 constants for 1.0 and 0.5
//   - FSM state enumeration used by the top level
//   - round_sat(): round-half-up right shift plus signed saturation,
//     written width-generic so any DATA_WIDTH / FRACTION_BITS pair can use it
// ---------------------------------------------------------------------------
package se_channel_scaler_pkg;

    localparam int SE_DATA_WIDTH    = 16;
    localparam int SE_FRACTION_BITS = 8;
    localparam int SE_NUM_CH        = 16;
    localparam int SE_NUM_PIX       = 49;

    localparam logic signed [SE_DATA_WIDTH-1:0] Q88_ONE  = 16'sh0100;
    localparam logic signed [SE_DATA_WIDTH-1:0] Q88_HALF = 16'sh0080;

    // IDLE waits for the first gate, LOAD fills the gate buffer, SCALE streams
    // the feature map and DRAIN empties the multiply pipeline.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SCALE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Adds half an LSB of the result, shifts arithmetically (floor), then
    // clamps into the signed dw-bit range. Carried at 64 bits so the caller
    // only has to truncate the already-clamped value.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] prod,
                                                     input int dw,
                                                     input int fb);
        logic signed [63:0] rounded;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        rounded = (prod + (64'sd1 <<< (fb - 1))) >>> fb;
        max_v   = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (dw - 1));
        if (rounded > max_v) begin
            return max_v;
        end
        if (rounded < min_v) begin
            return min_v;
        end
        return rounded;
    endfunction

endpackage

// File: rtl/se_channel_scaler_if.sv
// ---------------------------------------------------------------------------
// se_channel_scaler_if
//   Groups the three streams around the channel scaler:
//     scale_valid / scale_in                     gate words from H_Sigmoid
//     feat_valid / feat_ready / feat_in          feature map samples in
//     out_valid / out_ready / out_data / out_last  scaled samples out
//   slave  : view taken by the scaler itself
//   master : view taken by the surrounding logic (gate source, feature
//            source and downstream consumer)
// ---------------------------------------------------------------------------
interface se_channel_scaler_if #(
    parameter int DATA_WIDTH = 16
) ();

    logic                         scale_valid;
    logic signed [DATA_WIDTH-1:0] scale_in;

    logic                         feat_valid;
    logic                         feat_ready;
    logic signed [DATA_WIDTH-1:0] feat_in;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_last;

    modport slave (
        input  scale_valid,
        input  scale_in,
        input  feat_valid,
        output feat_ready,
        input  feat_in,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport master (
        output scale_valid,
        output scale_in,
        output feat_valid,
        input  feat_ready,
        output feat_in,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );

endinterface

// File: rtl/se_channel_scaler_qmul_round_sat.sv
// ---------------------------------------------------------------------------
// qmul_round_sat
//   Two-stage registered signed multiplier with rounding and saturation.
//     S1: prod = in_a * in_b at full 2*DW precision, last flag alongside
//     S2: round-half-up shift by FB, saturate to DW bits, drives the output
//   Each stage only loads when the stage after it can move, so a stalled
//   consumer freezes the output word instead of dropping or repeating it.
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      sample accepted this cycle (only asserted while adv=1)
//   in_a, in_b    signed operands (feature sample, channel gate)
//   in_last       final sample of the frame
//   out_ready     consumer accepts out_data
//   adv           pipeline can take a new sample this cycle
//   s1_valid      stage 1 occupied
//   s2_valid      stage 2 occupied (same as out_valid)
//   out_valid, out_data, out_last   result stream
// ---------------------------------------------------------------------------
module qmul_round_sat
    import se_channel_scaler_pkg::*;
#(
    parameter int DW = SE_DATA_WIDTH,
    parameter int FB = SE_FRACTION_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    input  logic                 in_last,
    input  logic                 out_ready,
    output logic                 adv,
    output logic                 s1_valid,
    output logic                 s2_valid,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic                 out_last
);

    localparam int PW = 2 * DW;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q,  s1_last_d;
    logic signed [PW-1:0] prod_q,     prod_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_last_q,  s2_last_d;
    logic signed [DW-1:0] s2_data_q,  s2_data_d;

    logic s1_en;
    logic s2_en;

    // Stage enables: S2 moves when empty or being consumed, S1 moves when
    // empty or when S2 is about to take its contents.
    always_comb begin
        s2_en = ~s2_valid_q | out_ready;
        s1_en = ~s1_valid_q | s2_en;
    end

    // Next-state for both stages. Data registers only load alongside a valid
    // word so the held output never changes underneath a stalled consumer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        prod_d     = prod_q;
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_data_d  = s2_data_q;

        if (s1_en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                prod_d    = PW'(in_a) * PW'(in_b);
                s1_last_d = in_last;
            end
        end

        if (s2_en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = DW'(round_sat(64'(prod_q), DW, FB));
                s2_last_d = s1_last_q;
            end
        end
    end

    // Pipeline registers; reset empties both stages and zeroes the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            prod_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            prod_q     <= prod_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign adv       = s1_en;
    assign s1_valid  = s1_valid_q;
    assign s2_valid  = s2_valid_q;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_last  = s2_last_q;

endmodule

// File: rtl/se_channel_scaler.sv
// ---------------------------------------------------------------------------
// se_channel_scaler
//   Squeeze-excite excitation stage. Captures NUM_CH per-channel Q8.8 gates
//   into a small register buffer, then streams a channel-interleaved feature
//   map and multiplies every sample by the gate of its channel. Results are
//   rounded half-up and saturated to Q8.8.
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bus        scaler view of the gate / feature / output streams
//   busy       high whenever the FSM is outside IDLE
//   done       one-cycle pulse once the last output has left the pipeline
//   scale_err  sticky flag: a gate arrived while a frame was being scaled
// ---------------------------------------------------------------------------
module se_channel_scaler
    import se_channel_scaler_pkg::*;
#(
    parameter int DATA_WIDTH    = SE_DATA_WIDTH,
    parameter int FRACTION_BITS = SE_FRACTION_BITS,
    parameter int NUM_CH        = SE_NUM_CH,
    parameter int NUM_PIX       = SE_NUM_PIX
) (
    input  logic                clk,
    input  logic                rst,
    se_channel_scaler_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                scale_err
);

    localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
    localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);

    state_t            state_q,     state_d;
    logic [CH_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [CH_W-1:0]   ch_cnt_q,    ch_cnt_d;
    logic [PIX_W-1:0]  pix_cnt_q,   pix_cnt_d;
    logic              scale_err_q, scale_err_d;

    logic signed [DATA_WIDTH-1:0] scale_ram_q [NUM_CH];
    logic                         ram_we;
    logic [CH_W-1:0]              ram_addr;

    logic adv;
    logic s1_valid;
    logic s2_valid;
    logic feat_hs;
    logic beat_last;
    logic pipe_empty;

    // A feature beat is the frame's last when both counters sit at their
    // final values; the flag travels down the pipeline with the sample.
    assign feat_hs    = bus.feat_valid & bus.feat_ready;
    assign beat_last  = (ch_cnt_q == CH_LAST) & (pix_cnt_q == PIX_LAST);
    assign pipe_empty = ~s1_valid & ~s2_valid;

    // State, counters and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            ch_cnt_q    <= '0;
            pix_cnt_q   <= '0;
            scale_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            ch_cnt_q    <= ch_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            scale_err_q <= scale_err_d;
        end
    end

    // Gate buffer is plain storage: it is never reset, every frame starts by
    // overwriting all NUM_CH entries before SCALE is reached.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            scale_ram_q[ram_addr] <= bus.scale_in;
        end
    end

    // Next-state logic. Gates are written in arrival order during IDLE/LOAD;
    // in SCALE/DRAIN they are refused and flagged instead, which also covers
    // a gate landing in the same cycle as the done pulse.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        ch_cnt_d    = ch_cnt_q;
        pix_cnt_d   = pix_cnt_q;
        scale_err_d = scale_err_q;
        ram_we      = 1'b0;
        ram_addr    = wr_ptr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.scale_valid) begin
                    ram_we   = 1'b1;
                    ram_addr = '0;
                    wr_ptr_d = CH_W'(1);
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (bus.scale_valid) begin
                    ram_we = 1'b1;
                    if (wr_ptr_q == CH_LAST) begin
                        wr_ptr_d = '0;
                        state_d  = SCALE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + CH_W'(1);
                    end
                end
            end
            SCALE: begin
                if (bus.scale_valid) begin
                    scale_err_d = 1'b1;
                end
                if (feat_hs) begin
                    if (ch_cnt_q == CH_LAST) begin
                        ch_cnt_d = '0;
                        if (pix_cnt_q == PIX_LAST) begin
                            pix_cnt_d = '0;
                            state_d   = DRAIN;
                        end else begin
                            pix_cnt_d = pix_cnt_q + PIX_W'(1);
                        end
                    end else begin
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (bus.scale_valid) begin
                    scale_err_d = 1'b1;
                end
                // The last beat entered S1 on the way into DRAIN, so an empty
                // pipeline here means the final output has been taken.
                if (pipe_empty) begin
                    state_d   = IDLE;
                    wr_ptr_d  = '0;
                    ch_cnt_d  = '0;
                    pix_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from registered state only.
    always_comb begin
        bus.feat_ready = (state_q == SCALE) & adv;
        busy           = (state_q != IDLE);
        done           = (state_q == DRAIN) & pipe_empty;
    end

    assign scale_err = scale_err_q;

    qmul_round_sat #(
        .DW (DATA_WIDTH),
        .FB (FRACTION_BITS)
    ) u_qmul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (feat_hs),
        .in_a      (bus.feat_in),
        .in_b      (scale_ram_q[ch_cnt_q]),
        .in_last   (beat_last),
        .out_ready (bus.out_ready),
        .adv       (adv),
        .s1_valid  (s1_valid),
        .s2_valid  (s2_valid),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last)
    );

endmodule
